// File: rtl/limber_gnrl_fifo_sync_prog.sv
// limber_gnrl_fifo_sync_prog
//   Single-clock FIFO of arbitrary depth DP (not limited to powers of two) with
//   an occupancy count, runtime-programmable almost-full / almost-empty
//   thresholds, synchronous flush and sticky overflow / underflow flags.
//
//   Build option: define LIMBER_FIFO_FWFT_EN for first-word-fall-through
//   operation. The head entry then sits in a one-entry output register that is
//   included in count, and empty reflects that register's valid bit. Without
//   the macro, reads have one cycle of latency and dout holds the last word read.
module limber_gnrl_fifo_sync_prog #(
  parameter  int DW = 8,
  parameter  int DP = 8,
  localparam int AW = $clog2(DP),
  localparam int CW = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          wen,
  input  logic          ren,
  input  logic          flush,
  input  logic [CW-1:0] afull_thr,
  input  logic [CW-1:0] aempty_thr,
  input  logic          clr_err,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          udf
);

  // Pointer wrap uses an explicit compare so that any depth works.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DP - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy update, saturating at both ends as a safety net.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic inc,
                                             input logic dec);
    logic [CW-1:0] r;
    r = c;
    if (inc && !dec && (c != CW'(DP))) r = c + 1'b1;
    if (dec && !inc && (c != '0))      r = c - 1'b1;
    return r;
  endfunction

  logic [DW-1:0] mem [DP];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic          wa;       // write accepted into the FIFO
  logic          ra;       // read accepted (entry leaves the FIFO)
  logic          mem_we;   // write lands in the storage array
  logic          rd_adv;   // storage array read pointer advances
  logic          ovf_set;
  logic          udf_set;

`ifdef LIMBER_FIFO_FWFT_EN
  logic          out_vld;  // output register holds the head entry
  logic [CW-1:0] mem_cnt;  // entries held in the array, excluding the output register
  logic          need_load;
  logic          load_mem;
  logic          bypass;

  // Head handling: refill the output register from the array when possible,
  // otherwise let an incoming write fall straight through to it.
  always_comb begin
    mem_cnt   = cnt - CW'(out_vld);
    wa        = wen & ~full & ~flush;
    ra        = ren & out_vld & ~flush;
    need_load = ~flush & (~out_vld | ra);
    load_mem  = need_load & (mem_cnt != '0);
    bypass    = need_load & (mem_cnt == '0) & wa;
    mem_we    = wa & ~bypass;
    rd_adv    = load_mem;
  end

  // Output register valid bit; cleared by flush together with the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (need_load) begin
      out_vld <= load_mem | bypass;
    end
  end

  // Head data: loaded from the array or bypassed from din; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (load_mem) begin
      dout <= mem[rptr];
    end else if (bypass) begin
      dout <= din;
    end
  end

  assign empty = ~out_vld;
`else
  // Standard mode: every accepted write goes to the array, reads pop from it.
  always_comb begin
    wa     = wen & ~full & ~flush;
    ra     = ren & ~empty & ~flush;
    mem_we = wa;
    rd_adv = ra;
  end

  // Read data register: updated only on an accepted read, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (ra) begin
      dout <= mem[rptr];
    end
  end

  assign empty = (cnt == '0);
`endif

  // Rejected requests only record errors; flush suppresses both.
  always_comb begin
    ovf_set = wen & full & ~flush;
    udf_set = ren & empty & ~flush;
  end

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr] <= din;
    end
  end

  // Write pointer, read pointer and occupancy; flush returns them to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (mem_we) wptr <= ptr_inc(wptr);
      if (rd_adv) rptr <= ptr_inc(rptr);
      cnt <= cnt_next(cnt, wa, ra);
    end
  end

  // Sticky error flags: a new violation wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (udf_set)      udf <= 1'b1;
      else if (clr_err) udf <= 1'b0;
    end
  end

  assign full   = (cnt == CW'(DP));
  assign afull  = (cnt >= afull_thr);
  assign aempty = (cnt <= aempty_thr);
  assign count  = cnt;

endmodule
